// File: rtl/game_stat_counter.sv
// Game-state counter feeding the seven-segment scanner: countdown timer on the
// high display word, saturating score on the low word, both held within 0..9999.
module game_stat_counter #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIME_LIMIT = 60,
  parameter int SCORE_MAX  = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic        score_inc,
  input  logic        score_dec,
  output logic [15:0] displayNumberHigh,
  output logic [15:0] displayNumberLow,
  output logic        running,
  output logic        game_over
);

  // state   | meaning
  // IDLE    | timer loaded with TIME_LIMIT, score 0, waiting for start
  // RUN     | prescaler counting, timer ticking, score pulses accepted
  // PAUSED  | prescaler, timer and score frozen, start resumes
  // OVER    | timer reached 0, everything frozen until clear/reset

  localparam int              PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_HZ - 1);
  localparam logic [15:0]     TIME_INIT = 16'(TIME_LIMIT);
  localparam logic [15:0]     SCORE_TOP = 16'(SCORE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [15:0]      time_q, time_d;
  logic [15:0]      score_q, score_d;
  logic             tick;
  logic             final_tick;

  assign tick       = (state_q == ST_RUN) && (presc_q == PRE_LAST);
  assign final_tick = tick && (time_q == 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The final tick beats a simultaneous pause so the game cannot stall at 0.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN: begin
          if (final_tick) begin
            state_d = ST_OVER;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: if (start) state_d = ST_RUN;
        ST_OVER:   state_d = ST_OVER;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    running   = (state_q == ST_RUN);
    game_over = (state_q == ST_OVER);
  end

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    score_d = score_q;
    if (clear || state_q == ST_IDLE) begin
      presc_d = '0;
      time_d  = TIME_INIT;
      score_d = '0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        presc_d = '0;
        if (time_q != 16'd0) begin
          time_d = time_q - 16'd1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
      case ({score_inc, score_dec})
        2'b10:   if (score_q < SCORE_TOP) score_d = score_q + 16'd1;
        2'b01:   if (score_q != 16'd0)    score_d = score_q - 16'd1;
        default: score_d = score_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      time_q  <= TIME_INIT;
      score_q <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
      score_q <= score_d;
    end
  end

  assign displayNumberHigh = time_q;
  assign displayNumberLow  = score_q;

endmodule

// File: tb/tb_game_stat_counter.sv
// Directed bench for game_stat_counter with CLK_HZ=10, TIME_LIMIT=3, SCORE_MAX=5.
module tb_game_stat_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic        score_inc = 1'b0;
  logic        score_dec = 1'b0;
  logic [15:0] displayNumberHigh;
  logic [15:0] displayNumberLow;
  logic        running;
  logic        game_over;

  int compared = 0;
  int mismatched = 0;

  game_stat_counter #(
    .CLK_HZ(10),
    .TIME_LIMIT(3),
    .SCORE_MAX(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .pause(pause),
    .clear(clear),
    .score_inc(score_inc),
    .score_dec(score_dec),
    .displayNumberHigh(displayNumberHigh),
    .displayNumberLow(displayNumberLow),
    .running(running),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    compared++;
    if (displayNumberHigh !== 16'd3) begin
      mismatched++;
      $display("FAIL reset_high: got %0d expected 3", displayNumberHigh);
    end
    compared++;
    if (displayNumberLow !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_low: got %0d expected 0", displayNumberLow);
    end
    compared++;
    if (running !== 1'b0 || game_over !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got running=%b game_over=%b expected 0/0", running, game_over);
    end
    start = 1'b1; cycles(1); start = 1'b0;
    score_inc = 1'b1; cycles(1); score_inc = 1'b0;
    cycles(10);
    compared++;
    if (running !== 1'b1 || displayNumberHigh !== 16'd2 || displayNumberLow !== 16'd1) begin
      mismatched++;
      $display("FAIL run_before_reset: got running=%b high=%0d low=%0d expected 1/2/1",
               running, displayNumberHigh, displayNumberLow);
    end
    reset = 1'b1; cycles(1); reset = 1'b0;
    compared++;
    if (running !== 1'b0 || game_over !== 1'b0 || displayNumberHigh !== 16'd3 || displayNumberLow !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_in_run: got running=%b game_over=%b high=%0d low=%0d expected 0/0/3/0",
               running, game_over, displayNumberHigh, displayNumberLow);
    end
  endtask

  task automatic test_countdown;
    clear = 1'b1; cycles(1); clear = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(9);
    compared++;
    if (displayNumberHigh !== 16'd3 || running !== 1'b1) begin
      mismatched++;
      $display("FAIL countdown_s9: got high=%0d running=%b expected 3/1", displayNumberHigh, running);
    end
    cycles(1);
    compared++;
    if (displayNumberHigh !== 16'd2) begin
      mismatched++;
      $display("FAIL countdown_s10: got %0d expected 2", displayNumberHigh);
    end
    cycles(10);
    compared++;
    if (displayNumberHigh !== 16'd1) begin
      mismatched++;
      $display("FAIL countdown_s20: got %0d expected 1", displayNumberHigh);
    end
    cycles(9);
    compared++;
    if (displayNumberHigh !== 16'd1 || running !== 1'b1 || game_over !== 1'b0) begin
      mismatched++;
      $display("FAIL countdown_s29: got high=%0d running=%b game_over=%b expected 1/1/0",
               displayNumberHigh, running, game_over);
    end
    cycles(1);
    compared++;
    if (displayNumberHigh !== 16'd0 || running !== 1'b0 || game_over !== 1'b1) begin
      mismatched++;
      $display("FAIL countdown_s30: got high=%0d running=%b game_over=%b expected 0/0/1",
               displayNumberHigh, running, game_over);
    end
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(12);
    compared++;
    if (game_over !== 1'b1 || running !== 1'b0 || displayNumberHigh !== 16'd0) begin
      mismatched++;
      $display("FAIL over_ignores_start: got game_over=%b running=%b high=%0d expected 1/0/0",
               game_over, running, displayNumberHigh);
    end
  endtask

  task automatic test_score_saturation;
    int exp_inc[7] = '{1, 2, 3, 4, 5, 5, 5};
    int exp_dec[6] = '{4, 3, 2, 1, 0, 0};
    clear = 1'b1; cycles(1); clear = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      score_inc = 1'b1; cycles(1); score_inc = 1'b0;
      compared++;
      if (displayNumberLow !== 16'(exp_inc[i])) begin
        mismatched++;
        $display("FAIL score_inc[%0d]: got %0d expected %0d", i, displayNumberLow, exp_inc[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      score_dec = 1'b1; cycles(1); score_dec = 1'b0;
      compared++;
      if (displayNumberLow !== 16'(exp_dec[i])) begin
        mismatched++;
        $display("FAIL score_dec[%0d]: got %0d expected %0d", i, displayNumberLow, exp_dec[i]);
      end
    end
    score_inc = 1'b1; cycles(1); score_inc = 1'b0;
    score_inc = 1'b1; score_dec = 1'b1; cycles(1);
    score_inc = 1'b0; score_dec = 1'b0;
    compared++;
    if (displayNumberLow !== 16'd1) begin
      mismatched++;
      $display("FAIL score_both: got %0d expected 1", displayNumberLow);
    end
  endtask

  task automatic test_pause_resume;
    clear = 1'b1; cycles(1); clear = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(3);
    pause = 1'b1; cycles(1); pause = 1'b0;
    compared++;
    if (running !== 1'b0 || game_over !== 1'b0 || displayNumberHigh !== 16'd3) begin
      mismatched++;
      $display("FAIL paused_state: got running=%b game_over=%b high=%0d expected 0/0/3",
               running, game_over, displayNumberHigh);
    end
    score_inc = 1'b1; cycles(1); score_inc = 1'b0;
    compared++;
    if (displayNumberLow !== 16'd0) begin
      mismatched++;
      $display("FAIL paused_score: got %0d expected 0", displayNumberLow);
    end
    cycles(48);
    compared++;
    if (displayNumberHigh !== 16'd3 || running !== 1'b0) begin
      mismatched++;
      $display("FAIL paused_hold: got high=%0d running=%b expected 3/0", displayNumberHigh, running);
    end
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(5);
    compared++;
    if (displayNumberHigh !== 16'd3 || running !== 1'b1) begin
      mismatched++;
      $display("FAIL resume_r5: got high=%0d running=%b expected 3/1", displayNumberHigh, running);
    end
    cycles(1);
    compared++;
    if (displayNumberHigh !== 16'd2) begin
      mismatched++;
      $display("FAIL resume_r6: got %0d expected 2", displayNumberHigh);
    end
  endtask

  task automatic test_final_tick_race;
    clear = 1'b1; cycles(1); clear = 1'b0;
    start = 1'b1; cycles(1); start = 1'b0;
    cycles(29);
    score_inc = 1'b1; cycles(1); score_inc = 1'b0;
    compared++;
    if (displayNumberLow !== 16'd1 || game_over !== 1'b1 || displayNumberHigh !== 16'd0) begin
      mismatched++;
      $display("FAIL final_tick_inc: got low=%0d game_over=%b high=%0d expected 1/1/0",
               displayNumberLow, game_over, displayNumberHigh);
    end
    score_inc = 1'b1; cycles(1); score_inc = 1'b0;
    compared++;
    if (displayNumberLow !== 16'd1) begin
      mismatched++;
      $display("FAIL over_score_frozen: got %0d expected 1", displayNumberLow);
    end
  endtask

  task automatic test_clear_priority;
    clear = 1'b1; start = 1'b1; cycles(1);
    clear = 1'b0; start = 1'b0;
    compared++;
    if (displayNumberHigh !== 16'd3 || displayNumberLow !== 16'd0 || running !== 1'b0 || game_over !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_with_start: got high=%0d low=%0d running=%b game_over=%b expected 3/0/0/0",
               displayNumberHigh, displayNumberLow, running, game_over);
    end
    start = 1'b1; cycles(1); start = 1'b0;
    compared++;
    if (running !== 1'b1) begin
      mismatched++;
      $display("FAIL start_after_clear: got running=%b expected 1", running);
    end
  endtask

  task automatic test_back_to_back;
    pause = 1'b1; start = 1'b1; cycles(1);
    pause = 1'b0; start = 1'b0;
    compared++;
    if (running !== 1'b0) begin
      mismatched++;
      $display("FAIL pause_over_start: got running=%b expected 0", running);
    end
    pause = 1'b1; start = 1'b1; cycles(1);
    pause = 1'b0; start = 1'b0;
    compared++;
    if (running !== 1'b1) begin
      mismatched++;
      $display("FAIL start_over_pause: got running=%b expected 1", running);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_score_saturation();
    test_pause_resume();
    test_final_tick_race();
    test_clear_priority();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
